// File: rtl/key_access_pkg.sv
// ============================================================================
// Module   : key_access_pkg
// Purpose  : Shared types and constants for the key access arbiter slice.
//            Holds the transaction FSM state encoding, the default key width
//            and the access-type encoding carried on req_write_i.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_access_pkg;

  // Default key width used by the top-level KEY_W parameter.
  localparam int KEY_W_DEF = 32;

  // Access-type encoding of a requester's req_write bit.
  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage : key_access_pkg

`default_nettype wire

// File: rtl/key_access_arbiter_rr.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin winner selection. The search starts at
//            ptr_i and wraps modulo NUM_REQ; the first set request bit found
//            wins. The pointer register itself lives in the caller.
// Ports    : req_i   [NUM_REQ]  request vector
//            ptr_i   [IDX_W]    search start index
//            gnt_o   [NUM_REQ]  one-hot winner (zero when no request)
//            idx_o   [IDX_W]    winner index (zero when no request)
//            valid_o            at least one request present
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IDX_W:0] w_pos;

  always_comb begin
    w_pos   = '0;
    idx_o   = '0;
    valid_o = |req_i;
    // Walk offsets from farthest to nearest so the nearest requester
    // (smallest offset from the pointer) is the last, winning assignment.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
      end
      if (req_i[w_pos[IDX_W-1:0]]) begin
        idx_o = w_pos[IDX_W-1:0];
      end
    end
    gnt_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/key_access_arbiter.sv
// ============================================================================
// Module   : key_access_arbiter
// Purpose  : Shares one secret-key storage block among NUM_REQ requesters.
//            Round-robin arbitration, per-requester read/write permission
//            masks and a sticky key lock. One transaction every 4 cycles:
//            IDLE (arbitrate/latch) -> ISSUE (storage strobe) -> WAIT
//            (storage output) -> RESP (response strobe).
// Ports    : clk, rst_n               clock, async active-low reset
//            req_i/req_write_i        per-requester request level / 1=write
//            req_wdata_i              write data, slice i for requester i
//            lock_set_i               pulse, sets the sticky key lock
//            gnt_o                    one-hot grant, ISSUE through RESP
//            rsp_valid_o/rsp_err_o    response strobe / access denied
//            rsp_data_o               read data (zero on write or deny)
//            key_locked_o             sticky lock status
//            ks_write_enable_o/ks_write_key_o/ks_read_enable_o  to storage
//            ks_key_output_i          from storage, valid 1 clk after read
//            deny_cnt_o/violation_o   audit outputs (KEY_ACCESS_AUDIT_EN)
// Options  : define KEY_ACCESS_AUDIT_EN to add the deny counter and the
//            sticky violation flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_access_arbiter
  import key_access_pkg::*;
#(
  parameter int                 NUM_REQ = 4,
  parameter int                 KEY_W   = KEY_W_DEF,
  parameter logic [NUM_REQ-1:0] WR_MASK = 4'b0001,
  parameter logic [NUM_REQ-1:0] RD_MASK = 4'b0011
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0]       req_write_i,
  input  logic [NUM_REQ*KEY_W-1:0] req_wdata_i,
  input  logic                     lock_set_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     rsp_valid_o,
  output logic                     rsp_err_o,
  output logic [KEY_W-1:0]         rsp_data_o,
  output logic                     key_locked_o,
  output logic                     ks_write_enable_o,
  output logic [KEY_W-1:0]         ks_write_key_o,
  output logic                     ks_read_enable_o,
`ifdef KEY_ACCESS_AUDIT_EN
  output logic [7:0]               deny_cnt_o,
  output logic                     violation_o,
`endif
  input  logic [KEY_W-1:0]         ks_key_output_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e               state_q,    state_d;
  logic [IDX_W-1:0]     ptr_q,      ptr_d;
  logic [IDX_W-1:0]     idx_q,      idx_d;
  logic [NUM_REQ-1:0]   gnt_q,      gnt_d;
  logic                 wr_q,       wr_d;
  logic                 perm_q,     perm_d;
  logic [KEY_W-1:0]     rdata_q,    rdata_d;
  logic                 locked_q,   locked_d;
  logic                 ks_we_q,    ks_we_d;
  logic                 ks_re_q,    ks_re_d;
  logic [KEY_W-1:0]     ks_key_q,   ks_key_d;

  // Arbiter results and selected write data for the current IDLE cycle.
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [KEY_W-1:0]     sel_wdata;
  logic                 sel_write;
  logic                 issue_wr_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_wdata = req_wdata_i[i*KEY_W +: KEY_W];
      end
    end
  end

  assign sel_write = req_write_i[arb_idx];

  // Write permission as seen during ISSUE. A lock_set arriving in the ISSUE
  // cycle itself must also deny the write, so the live input is included.
  assign issue_wr_ok = WR_MASK[idx_q] & ~(locked_q | lock_set_i);

  // --------------------------------------------------------------------------
  // Process 1: state register (plus datapath registers)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      wr_q     <= ACC_READ;
      perm_q   <= 1'b0;
      rdata_q  <= '0;
      locked_q <= 1'b0;
      ks_we_q  <= 1'b0;
      ks_re_q  <= 1'b0;
      ks_key_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      perm_q   <= perm_d;
      rdata_q  <= rdata_d;
      locked_q <= locked_d;
      ks_we_q  <= ks_we_d;
      ks_re_q  <= ks_re_d;
      ks_key_q <= ks_key_d;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state and datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    perm_d   = perm_q;
    rdata_d  = rdata_q;
    locked_d = locked_q | lock_set_i;
    // Storage strobes are single-cycle: they default low every cycle.
    ks_we_d  = 1'b0;
    ks_re_d  = 1'b0;
    ks_key_d = '0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          idx_d   = arb_idx;
          gnt_d   = arb_gnt;
          wr_d    = sel_write;
          // Strobes are registered so they appear during ISSUE. key_locked
          // in ISSUE equals locked_q | lock_set_i seen here.
          ks_we_d = (sel_write == ACC_WRITE) & WR_MASK[arb_idx]
                    & ~(locked_q | lock_set_i);
          ks_re_d = (sel_write == ACC_READ) & RD_MASK[arb_idx];
          ks_key_d = ks_we_d ? sel_wdata : '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        perm_d  = (wr_q == ACC_WRITE) ? issue_wr_ok : RD_MASK[idx_q];
        state_d = WAIT;
      end
      WAIT: begin
        // Key bits only enter the response register for a permitted read.
        rdata_d = (perm_q && (wr_q == ACC_READ)) ? ks_key_output_i : '0;
        state_d = RESP;
      end
      RESP: begin
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Process 3: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_o        = '0;
    rsp_valid_o  = 1'b0;
    rsp_err_o    = 1'b0;
    rsp_data_o   = '0;
    key_locked_o = locked_q;

    if (state_q != IDLE) begin
      gnt_o = gnt_q;
    end
    if (state_q == RESP) begin
      rsp_valid_o = 1'b1;
      rsp_err_o   = ~perm_q;
      rsp_data_o  = rdata_q;
    end

    // A lock_set coincident with ISSUE suppresses the pending write; the
    // storage samples at the end of ISSUE, so this gate is sufficient.
    ks_write_enable_o = ks_we_q & ~lock_set_i;
    ks_write_key_o    = ks_key_q & {KEY_W{~lock_set_i}};
    ks_read_enable_o  = ks_re_q;
  end

`ifdef KEY_ACCESS_AUDIT_EN
  // --------------------------------------------------------------------------
  // Audit: saturating deny counter and sticky violation flag
  // --------------------------------------------------------------------------
  logic [7:0] deny_cnt_q;
  logic       violation_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deny_cnt_q  <= '0;
      violation_q <= 1'b0;
    end else if ((state_q == RESP) && !perm_q) begin
      if (deny_cnt_q != 8'hFF) begin
        deny_cnt_q <= deny_cnt_q + 8'd1;
      end
      violation_q <= 1'b1;
    end
  end

  assign deny_cnt_o  = deny_cnt_q;
  assign violation_o = violation_q;
`endif

endmodule : key_access_arbiter

`default_nettype wire
